// File: rtl/phy_pkg.sv
// Shared PHY definitions: serial TX state encoding, COM symbol, symbol width.
package phy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam int         SYM_W   = 8;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: after reset sends MIN_COM COM symbols, then
// streams accepted bytes MSB first, filling empty slots with COM.
// Optional: define PS_TX_BYTE_CNT_EN to add the byte_cnt output.
module paralelo_serial_tx
  import phy_pkg::*;
#(
  parameter int MIN_COM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_ready,
  output logic       out_tx,
  output logic       active_out
`ifdef PS_TX_BYTE_CNT_EN
  ,
  output logic [15:0] byte_cnt
`endif
);

  localparam logic [3:0] COM_LAST = 4'(MIN_COM - 1);
  localparam logic [2:0] BIT_LAST = 3'(SYM_W - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] com_q, com_d;
  logic [7:0] sh_q, sh_d;
  logic       sym_end, last_com, capture;

  assign sym_end    = (bit_q == BIT_LAST);
  assign last_com   = (com_q == COM_LAST);
  // Slot opens on the last bit of a symbol whose successor is an ACTIVE symbol.
  assign data_ready = sym_end && ((state_q == ACTIVE) || ((state_q == SYNC) && last_com));
  assign capture    = data_ready && valid_in;
  assign out_tx     = sh_q[7];
  assign active_out = (state_q == ACTIVE);

  // Next-state, counter and shifter logic.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    com_d   = com_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        state_d = SYNC;
        sh_d    = COM_SYM;
        bit_d   = 3'd0;
        com_d   = 4'd0;
      end
      SYNC, ACTIVE: begin
        if (sym_end) begin
          bit_d = 3'd0;
          sh_d  = capture ? data_in : COM_SYM;
          if (state_q == SYNC) begin
            if (last_com) state_d = ACTIVE;
            else          com_d   = com_q + 4'd1;
          end
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and shift register; reset discards any partial symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      com_q   <= 4'd0;
      sh_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      com_q   <= com_d;
      sh_q    <= sh_d;
    end
  end

`ifdef PS_TX_BYTE_CNT_EN
  // Count accepted data bytes, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       byte_cnt <= 16'd0;
    else if (capture) byte_cnt <= byte_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: stimulus pushes expected bits,
// monitor pops and compares out_tx/data_ready/active_out every bit.
module tb_paralelo_serial_tx;

  localparam logic [7:0] COM = 8'hBC;
  localparam int NCOM = 4;

  typedef struct { logic o; logic rdy; logic act; } exp_t;
  typedef struct { logic v; logic [7:0] d; } slot_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       data_ready, out_tx, active_out;
`ifdef PS_TX_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  exp_t  exp_q[$];
  slot_t slots[$];
  int    checks = 0;
  int    failures = 0;

  paralelo_serial_tx #(.MIN_COM(NCOM)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_ready (data_ready),
    .out_tx     (out_tx),
    .active_out (active_out)
`ifdef PS_TX_BYTE_CNT_EN
    ,
    .byte_cnt   (byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_sym(input logic [7:0] s, input logic act, input logic rdy_end);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.o   = s[i];
      e.rdy = (i == 0) && rdy_end;
      e.act = act;
      exp_q.push_back(e);
    end
  endtask

  task automatic add_slot(input logic v, input logic [7:0] d);
    slot_t s;
    s.v = v;
    s.d = d;
    slots.push_back(s);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("rst_out_tx", {15'd0, out_tx}, 16'd0);
    check("rst_data_ready", {15'd0, data_ready}, 16'd0);
    check("rst_active_out", {15'd0, active_out}, 16'd0);
  endtask

  // Hold reset, then release with the sync COMs expected.
  task automatic start_seq(input logic pre_v, input logic [7:0] pre_d);
    assert_reset();
    repeat (2) @(negedge clk);
    valid_in = pre_v;
    data_in  = pre_d;
    reset    = 1'b1;
    for (int k = 0; k < NCOM; k++) push_sym(COM, 1'b0, k == NCOM - 1);
  endtask

  task automatic run_slots();
    slot_t s;
    logic  got;
    while (slots.size() > 0) begin
      s   = slots.pop_front();
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (data_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL slot_timeout: data_ready never rose, expected within 40 cycles");
        slots.delete();
      end else begin
        valid_in = s.v;
        data_in  = s.d;
        push_sym(s.v ? s.d : COM, 1'b1, 1'b1);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk);
      #3;
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: %0d expected bits left, expected 0", exp_q.size());
    exp_q.delete();
  endtask

  // Monitor: one expected bit per clock, sampled after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_tx", {15'd0, out_tx}, {15'd0, e.o});
        check("data_ready", {15'd0, data_ready}, {15'd0, e.rdy});
        check("active_out", {15'd0, active_out}, {15'd0, e.act});
      end
    end
  end

  initial begin
    // Idle after release: only COMs, ready at bit 32, active from bit 33.
    start_seq(1'b0, 8'h00);
    for (int k = 0; k < 4; k++) add_slot(1'b0, 8'h00);
    run_slots();
    drain();

    // Back-to-back EE/FF pairs.
    start_seq(1'b0, 8'h00);
    for (int k = 0; k < 64; k++) begin
      add_slot(1'b1, 8'hEE);
      add_slot(1'b1, 8'hFF);
    end
    run_slots();
    drain();

    // One empty slot between two bytes gives a COM fill.
    start_seq(1'b0, 8'h00);
    add_slot(1'b1, 8'hEE);
    add_slot(1'b0, 8'h00);
    add_slot(1'b1, 8'hFF);
    run_slots();
    drain();

    // valid_in high during SYNC is ignored until the slot opens.
    start_seq(1'b1, 8'h55);
    add_slot(1'b1, 8'hA5);
    run_slots();
    drain();

    // Reset mid-byte, then a full resync before the next byte.
    start_seq(1'b0, 8'h00);
    add_slot(1'b1, 8'hC3);
    run_slots();
    repeat (2) @(posedge clk);
    assert_reset();
    start_seq(1'b0, 8'h00);
    add_slot(1'b1, 8'h5A);
    run_slots();
    drain();

`ifdef PS_TX_BYTE_CNT_EN
    start_seq(1'b0, 8'h00);
    add_slot(1'b1, 8'h11);
    add_slot(1'b1, 8'h22);
    add_slot(1'b1, 8'h33);
    run_slots();
    drain();
    check("byte_cnt_3", byte_cnt, 16'd3);
    @(negedge clk);
    force dut.byte_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.byte_cnt;
    add_slot(1'b1, 8'h44);
    run_slots();
    drain();
    check("byte_cnt_wrap", byte_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_tx.md
PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 SHALL have parameter MIN_COM, default 4, meaning the number of COM symbols sent after reset before data is accepted (range 1..15).
REQ-002 SHALL have port clk  input  1  serial bit clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port data_in  input  8  parallel byte to transmit.
REQ-005 SHALL have port valid_in  input  1  data_in holds a byte to send.
REQ-006 SHALL have port data_ready  output  1  byte slot open; data_in is taken on this edge if valid_in=1.
REQ-007 SHALL have port out_tx  output  1  serial stream, MSB first, one bit per clk; feeds the receiver's in_rx_tx input.
REQ-008 SHALL have port active_out  output  1  high while in state ACTIVE.

Function
REQ-009 SHALL implement the states IDLE, SYNC and ACTIVE.
REQ-010 SHALL leave IDLE for SYNC on the first rising edge after reset deasserts.
REQ-011 SHALL send exactly MIN_COM COM symbols (8'hBC = 10111100) in SYNC, then move to ACTIVE at the symbol boundary.
REQ-012 SHALL drive out_tx from a register, with the first COM bit (1) valid after the first edge in SYNC.
REQ-013 SHALL send every symbol as 8 consecutive bits, MSB first, with no gap cycles between symbols.
REQ-014 SHALL assert data_ready only while the last bit (bit 0) of a symbol is on out_tx and the next symbol belongs to ACTIVE (in ACTIVE, or during the final SYNC symbol).
REQ-015 SHALL, at an edge where data_ready=1 and valid_in=1, capture data_in so that its bit 7 appears on out_tx in the next cycle.
REQ-016 SHALL, at an edge where data_ready=1 and valid_in=0, send a COM symbol next (idle fill).
REQ-017 SHALL ignore valid_in and data_in whenever data_ready=0, including all of SYNC before its final symbol.
REQ-018 SHALL use a 3-bit bit counter that wraps 7->0 at each symbol boundary, and a 4-bit COM counter that is compared against MIN_COM-1.
REQ-019 SHALL remain in ACTIVE until reset, with no return to SYNC on idle fill.
REQ-020 SHALL assert active_out on the cycle in which the first post-SYNC symbol bit is driven.

Reset
REQ-021 SHALL, while reset=0, hold out_tx=0, data_ready=0, active_out=0, state=IDLE, with both counters and the shift register at 0.
REQ-022 SHALL, on reset asserted mid-symbol, force outputs to their reset values immediately, discarding the partial symbol.
REQ-023 SHALL, after reset is released, repeat the full SYNC sequence of MIN_COM COM symbols.

Configuration
REQ-024 SHALL, with macro PS_TX_BYTE_CNT_EN defined, add output byte_cnt  output  16, counting accepted data bytes; it resets to 0, increments on each capture and wraps 16'hFFFF->0.
REQ-025 SHALL, without PS_TX_BYTE_CNT_EN defined, have no byte_cnt port and no counter logic.

Structure
REQ-026 SHALL take the state encoding (IDLE/SYNC/ACTIVE), the COM_SYM=8'hBC constant and the symbol width 8 from the shared package phy_pkg.
REQ-027 SHALL be a single module with no sub-modules; the shifter and the FSM stay inline.

Verification
REQ-028 SHALL cover: reset release with valid_in=0 -> out_tx repeats 10111100 indefinitely, data_ready first high at the 32nd bit (MIN_COM=4), active_out high from the 33rd bit.
REQ-029 SHALL cover: valid_in held 1 with alternating data 8'hEE/8'hFF -> after 4 COM symbols out_tx = 11101110 11111111 back-to-back, gapless, 64 pairs.
REQ-030 SHALL cover: one 8'hEE accepted, then valid_in=0 for one slot, then 8'hFF -> out_tx 11101110 10111100 11111111.
REQ-031 SHALL cover: valid_in=1 with data 8'h55 during the first 3 SYNC symbols -> no capture and out_tx unaffected; the first data byte appears only after the 4th COM symbol.
REQ-032 SHALL cover: reset asserted at bit 3 of a data byte -> out_tx=0, data_ready=0 and active_out=0 in the same cycle; after release, 4 COM symbols again before any data.
REQ-033 SHALL cover, with PS_TX_BYTE_CNT_EN defined: 3 accepted bytes -> byte_cnt=3; starting from a forced 16'hFFFF, one capture -> byte_cnt=0.
